sm83_regfile: RTL and testbench
===============================

SM83_REGFILE -- requirements
Module: sm83_regfile

Interface
REQ-001 SHALL have parameter PC_RST, default 16'h0000, PC reset value.
REQ-002 SHALL have parameter SP_RST, default 16'hFFFE, SP reset value.
REQ-003 SHALL have parameter AF_RST, default 16'h01B0, AF reset value; BC/DE/HL reset to 16'h0000.
REQ-004 SHALL have ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd8a_sel  in  3  r8 select: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A.
- rd8a_data  out  8  read port A data.
- rd8b_sel  in  3  as rd8a_sel.
- rd8b_data  out  8  read port B data.
- rd16_sel  in  3  r16 select: 0 BC, 1 DE, 2 HL, 3 SP, 4 AF, 5 PC; 6 and 7 reserved.
- rd16_data  out  16  pair read data.
- wr8_en  in  1  8-bit write strobe.
- wr8_sel  in  3  r8 write target.
- wr8_data  in  8  8-bit write data.
- wr16_en  in  1  pair write strobe.
- wr16_sel  in  3  r16 write target.
- wr16_data  in  16  pair write data.
- idu_en  in  1  inc/dec request.
- idu_sel  in  3  r16 target.
- idu_op  in  2  00 inc, 01 dec, 10 and 11 hold.
- flg_we  in  4  per-flag write mask {Z,N,H,C}.
- flg_in  in  4  flag values {Z,N,H,C}.
- pc_q, sp_q, hl_q  out  16  always-visible copies.
- idu_q  out  16  registered last IDU result.

Function
REQ-005 SHALL keep all registers in flops, with muxed reads and no tristates.
REQ-006 SHALL drive reads combinationally from current register state.
REQ-007 SHALL read rd16 sel 6/7 as 16'h0000.
REQ-008 SHALL ignore writes and IDU requests to reserved r16 selects.
REQ-009 SHALL update all writes on the rising clk edge, one-cycle write latency.
REQ-010 SHALL hold F[3:0] at 0 always, regardless of write data.
REQ-011 SHALL make IDU inc/dec wrap modulo 2^16 (FFFF+1=0000, 0000-1=FFFF).
REQ-012 SHALL write the IDU result back to idu_sel and load idu_q in the same edge.
REQ-013 SHALL merge non-conflicting writes in one cycle.
REQ-014 SHALL resolve same-byte conflicts with priority wr16 > idu > wr8 > flg_we.
REQ-015 SHALL let wr8 to F be overridden per-bit by flg_we, so flg_we wins on bits 7:4 despite its lower priority.
REQ-016 SHALL let a losing source's non-overlapping byte still commit (e.g. wr16 BC with wr8 A: both land).
REQ-017 SHALL perform only one write when idu and wr16 hit the same pair: wr16 wins; idu_q still loads the IDU result.

Reset
REQ-018 SHALL set PC=PC_RST, SP=SP_RST, AF=AF_RST&16'hFFF0, BC=DE=HL=0 and idu_q=0 while rst is low, independent of clk.
REQ-019 SHALL ignore all strobes while rst is low and on the deasserting edge.
REQ-020 SHALL drop any write in flight when reset asserts mid-operation.

Configuration
REQ-021 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle pending write data (post-priority, post-F-masking) to every read port and pc_q/sp_q/hl_q.
REQ-022 SHALL, without REGFILE_BYPASS_EN, show new values only after the edge.

Structure
REQ-023 SHALL take r8 encodings, r16 encodings, IDU op codes and the flag bit positions from shared package sm83_pkg.
REQ-024 SHALL implement the 16-bit inc/dec as sub-module sm83_idu, combinational with 2-bit op, instantiated once.

Verification
REQ-025 SHALL cover reset: release rst -> PC=0000, SP=FFFE, AF=01B0, BC=0000, idu_q=0000.
REQ-026 SHALL cover IDU wrap: wr16 HL=FFFF, then idu inc HL -> HL=0000, idu_q=0000; idu dec SP from 0000 -> SP=FFFF.
REQ-027 SHALL cover conflicts: wr16 BC=1234 with wr8 C=99 same cycle -> BC=1234; wr16 DE=5678 with wr8 A=AA -> DE=5678, A=AA.
REQ-028 SHALL cover flags: wr8 F=FF with flg_we=0001, flg_in=0000 -> F=E0; wr16 AF=12FF -> F reads F0.
REQ-029 SHALL cover bypass: wr8 B=5A, rd8a_sel=B same cycle -> 5A with REGFILE_BYPASS_EN, old B without.
REQ-030 SHALL cover async reset: assert rst low mid-cycle with wr16 PC=C000 pending -> PC=0000 immediately, no C000 after release.

Source files
------------

// File: rtl/sm83_pkg.sv
// ---------------------------------------------------------------------------
// sm83_pkg
// Shared encodings for the SM83 register file: 8-bit register selects,
// 16-bit pair selects, IDU op codes, flag bit positions, and helpers that map
// a pair select onto its high/low 8-bit register slots.
// ---------------------------------------------------------------------------
package sm83_pkg;

    // 8-bit register selects (also the slot index in the byte storage)
    localparam logic [2:0] R8_B = 3'd0;
    localparam logic [2:0] R8_C = 3'd1;
    localparam logic [2:0] R8_D = 3'd2;
    localparam logic [2:0] R8_E = 3'd3;
    localparam logic [2:0] R8_H = 3'd4;
    localparam logic [2:0] R8_L = 3'd5;
    localparam logic [2:0] R8_F = 3'd6;
    localparam logic [2:0] R8_A = 3'd7;

    // 16-bit pair selects; 6 and 7 are reserved
    localparam logic [2:0] R16_BC = 3'd0;
    localparam logic [2:0] R16_DE = 3'd1;
    localparam logic [2:0] R16_HL = 3'd2;
    localparam logic [2:0] R16_SP = 3'd3;
    localparam logic [2:0] R16_AF = 3'd4;
    localparam logic [2:0] R16_PC = 3'd5;

    typedef enum logic [1:0] {
        IDU_INC   = 2'b00,
        IDU_DEC   = 2'b01,
        IDU_HOLD  = 2'b10,
        IDU_HOLD2 = 2'b11
    } idu_op_e;

    // Flag positions inside the 4-bit {Z,N,H,C} mask/value buses
    localparam int FLG_C = 0;
    localparam int FLG_H = 1;
    localparam int FLG_N = 2;
    localparam int FLG_Z = 3;

    // Flag nibble lives in F[7:4]
    localparam int F_FLAG_BASE = 4;

    function automatic logic [2:0] pair_hi(input logic [2:0] sel);
        case (sel)
            R16_DE:  return R8_D;
            R16_HL:  return R8_H;
            R16_AF:  return R8_A;
            default: return R8_B;
        endcase
    endfunction

    function automatic logic [2:0] pair_lo(input logic [2:0] sel);
        case (sel)
            R16_DE:  return R8_E;
            R16_HL:  return R8_L;
            R16_AF:  return R8_F;
            default: return R8_C;
        endcase
    endfunction

endpackage

// File: rtl/sm83_idu.sv
// ---------------------------------------------------------------------------
// sm83_idu
// Combinational 16-bit increment/decrement unit. Wraps modulo 2^16.
// Ports:
//   din  in  16  operand
//   op   in   2  00 inc, 01 dec, 10/11 pass-through
//   dout out 16  result
// ---------------------------------------------------------------------------
module sm83_idu
    import sm83_pkg::*;
(
    input  logic [15:0] din,
    input  logic [1:0]  op,
    output logic [15:0] dout
);

    always_comb begin
        dout = din;
        case (idu_op_e'(op))
            IDU_INC: dout = din + 16'd1;
            IDU_DEC: dout = din - 16'd1;
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/sm83_regfile.sv
// ---------------------------------------------------------------------------
// sm83_regfile
// SM83 register file: B,C,D,E,H,L,A,F bytes plus SP and PC, two 8-bit read
// ports, one 16-bit pair read port, 8-bit / 16-bit / IDU / flag writes merged
// per byte with priority wr16 > idu > wr8 > flags (flags still override a wr8
// to F bit-by-bit). F[3:0] is always zero.
// Optional feature: define REGFILE_BYPASS_EN to forward the pending
// (post-priority) write data to all read ports and pc_q/sp_q/hl_q.
// Ports:
//   clk, rst (async active-low)
//   rd8a_sel/rd8a_data, rd8b_sel/rd8b_data   8-bit reads
//   rd16_sel/rd16_data                       pair read (sel 6/7 read 0)
//   wr8_en/wr8_sel/wr8_data                  8-bit write
//   wr16_en/wr16_sel/wr16_data               pair write
//   idu_en/idu_sel/idu_op                    pair inc/dec with write-back
//   flg_we/flg_in                            per-flag {Z,N,H,C} writes
//   pc_q, sp_q, hl_q                         always-visible pairs
//   idu_q                                    last IDU result (registered)
// ---------------------------------------------------------------------------
module sm83_regfile
    import sm83_pkg::*;
#(
    parameter logic [15:0] PC_RST = 16'h0000,
    parameter logic [15:0] SP_RST = 16'hFFFE,
    parameter logic [15:0] AF_RST = 16'h01B0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd8a_sel,
    output logic [7:0]  rd8a_data,
    input  logic [2:0]  rd8b_sel,
    output logic [7:0]  rd8b_data,
    input  logic [2:0]  rd16_sel,
    output logic [15:0] rd16_data,
    input  logic        wr8_en,
    input  logic [2:0]  wr8_sel,
    input  logic [7:0]  wr8_data,
    input  logic        wr16_en,
    input  logic [2:0]  wr16_sel,
    input  logic [15:0] wr16_data,
    input  logic        idu_en,
    input  logic [2:0]  idu_sel,
    input  logic [1:0]  idu_op,
    input  logic [3:0]  flg_we,
    input  logic [3:0]  flg_in,
    output logic [15:0] pc_q,
    output logic [15:0] sp_q,
    output logic [15:0] hl_q,
    output logic [15:0] idu_q
);

    // Byte storage indexed by r8 select: {A, F, L, H, E, D, C, B}
    localparam logic [7:0][7:0] R8_RST = {AF_RST[15:8], AF_RST[7:4], 4'h0, 48'h0};

    logic [7:0][7:0] r8_q, r8_d;
    logic [15:0]     sp_val_q, sp_val_d;
    logic [15:0]     pc_val_q, pc_val_d;
    logic [15:0]     idu_d;

    logic [15:0]     idu_src, idu_res;
    logic            wr8_go, wr16_go, idu_go;
    logic [3:0]      flg_go;

    logic [7:0][7:0] view_r8;
    logic [15:0]     view_sp, view_pc;

    function automatic logic [15:0] pair_read(input logic [7:0][7:0] r8,
                                              input logic [15:0] sp,
                                              input logic [15:0] pc,
                                              input logic [2:0]  sel);
        case (sel)
            R16_BC, R16_DE, R16_HL, R16_AF: return {r8[pair_hi(sel)], r8[pair_lo(sel)]};
            R16_SP:  return sp;
            R16_PC:  return pc;
            default: return 16'h0000;
        endcase
    endfunction

    // Strobes are qualified with rst so nothing is staged (or bypassed)
    // while reset is held; reserved pair selects never qualify.
    assign wr8_go  = wr8_en & rst;
    assign wr16_go = wr16_en & rst & (wr16_sel <= R16_PC);
    assign idu_go  = idu_en & rst & (idu_sel <= R16_PC) &
                     ((idu_op == IDU_INC) || (idu_op == IDU_DEC));
    assign flg_go  = flg_we & {4{rst}};

    assign idu_src = pair_read(r8_q, sp_val_q, pc_val_q, idu_sel);

    sm83_idu u_idu (
        .din  (idu_src),
        .op   (idu_op),
        .dout (idu_res)
    );

    // Writes are applied lowest priority first so later sources overwrite
    // only the bytes they touch; flags follow wr8 so they win on F[7:4].
    always_comb begin
        r8_d     = r8_q;
        sp_val_d = sp_val_q;
        pc_val_d = pc_val_q;
        idu_d    = idu_q;

        if (wr8_go) begin
            r8_d[wr8_sel] = wr8_data;
        end

        if (flg_go[FLG_Z]) r8_d[R8_F][F_FLAG_BASE + FLG_Z] = flg_in[FLG_Z];
        if (flg_go[FLG_N]) r8_d[R8_F][F_FLAG_BASE + FLG_N] = flg_in[FLG_N];
        if (flg_go[FLG_H]) r8_d[R8_F][F_FLAG_BASE + FLG_H] = flg_in[FLG_H];
        if (flg_go[FLG_C]) r8_d[R8_F][F_FLAG_BASE + FLG_C] = flg_in[FLG_C];

        if (idu_go) begin
            idu_d = idu_res;
            case (idu_sel)
                R16_SP:  sp_val_d = idu_res;
                R16_PC:  pc_val_d = idu_res;
                default: begin
                    r8_d[pair_hi(idu_sel)] = idu_res[15:8];
                    r8_d[pair_lo(idu_sel)] = idu_res[7:0];
                end
            endcase
        end

        if (wr16_go) begin
            case (wr16_sel)
                R16_SP:  sp_val_d = wr16_data;
                R16_PC:  pc_val_d = wr16_data;
                default: begin
                    r8_d[pair_hi(wr16_sel)] = wr16_data[15:8];
                    r8_d[pair_lo(wr16_sel)] = wr16_data[7:0];
                end
            endcase
        end

        r8_d[R8_F][3:0] = 4'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r8_q     <= R8_RST;
            sp_val_q <= SP_RST;
            pc_val_q <= PC_RST;
            idu_q    <= 16'h0000;
        end else begin
            r8_q     <= r8_d;
            sp_val_q <= sp_val_d;
            pc_val_q <= pc_val_d;
            idu_q    <= idu_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign view_r8 = r8_d;
    assign view_sp = sp_val_d;
    assign view_pc = pc_val_d;
`else
    assign view_r8 = r8_q;
    assign view_sp = sp_val_q;
    assign view_pc = pc_val_q;
`endif

    assign rd8a_data = view_r8[rd8a_sel];
    assign rd8b_data = view_r8[rd8b_sel];
    assign rd16_data = pair_read(view_r8, view_sp, view_pc, rd16_sel);
    assign pc_q      = view_pc;
    assign sp_q      = view_sp;
    assign hl_q      = {view_r8[R8_H], view_r8[R8_L]};

endmodule

// File: tb/tb_sm83_regfile.sv
// ---------------------------------------------------------------------------
// tb_sm83_regfile
// Directed scenarios plus a randomized run against a pair-level reference
// model of the SM83 register file.
// ---------------------------------------------------------------------------
module tb_sm83_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  rd8a_sel, rd8b_sel, rd16_sel;
    logic [7:0]  rd8a_data, rd8b_data;
    logic [15:0] rd16_data;
    logic        wr8_en, wr16_en, idu_en;
    logic [2:0]  wr8_sel, wr16_sel, idu_sel;
    logic [7:0]  wr8_data;
    logic [15:0] wr16_data;
    logic [1:0]  idu_op;
    logic [3:0]  flg_we, flg_in;
    logic [15:0] pc_q, sp_q, hl_q, idu_q;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: six pairs in select order BC, DE, HL, SP, AF, PC
    logic [15:0] m_r [6];
    logic [15:0] n_r [6];
    logic [15:0] m_idu, n_idu;
    int r8_pair [8] = '{0, 0, 1, 1, 2, 2, 4, 4};
    bit r8_hi   [8] = '{1, 0, 1, 0, 1, 0, 0, 1};

    sm83_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .rd8a_sel  (rd8a_sel),
        .rd8a_data (rd8a_data),
        .rd8b_sel  (rd8b_sel),
        .rd8b_data (rd8b_data),
        .rd16_sel  (rd16_sel),
        .rd16_data (rd16_data),
        .wr8_en    (wr8_en),
        .wr8_sel   (wr8_sel),
        .wr8_data  (wr8_data),
        .wr16_en   (wr16_en),
        .wr16_sel  (wr16_sel),
        .wr16_data (wr16_data),
        .idu_en    (idu_en),
        .idu_sel   (idu_sel),
        .idu_op    (idu_op),
        .flg_we    (flg_we),
        .flg_in    (flg_in),
        .pc_q      (pc_q),
        .sp_q      (sp_q),
        .hl_q      (hl_q),
        .idu_q     (idu_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] exp8(input logic [2:0] sel, input bit nxt);
        logic [15:0] v;
        v = nxt ? n_r[r8_pair[sel]] : m_r[r8_pair[sel]];
        return r8_hi[sel] ? v[15:8] : v[7:0];
    endfunction

    function automatic logic [15:0] exp16(input logic [2:0] sel, input bit nxt);
        if (sel > 3'd5) return 16'h0000;
        return nxt ? n_r[sel] : m_r[sel];
    endfunction

    task automatic model_reset();
        m_r[0] = 16'h0000; m_r[1] = 16'h0000; m_r[2] = 16'h0000;
        m_r[3] = 16'hFFFE; m_r[4] = 16'h01B0; m_r[5] = 16'h0000;
        m_idu  = 16'h0000;
    endtask

    // Next state: apply sources lowest priority first, then clear F low nibble
    task automatic model_next();
        logic [15:0] res;
        for (int i = 0; i < 6; i++) n_r[i] = m_r[i];
        n_idu = m_idu;
        if (rst) begin
            if (wr8_en) begin
                if (r8_hi[wr8_sel]) n_r[r8_pair[wr8_sel]][15:8] = wr8_data;
                else                n_r[r8_pair[wr8_sel]][7:0]  = wr8_data;
            end
            for (int k = 0; k < 4; k++) if (flg_we[k]) n_r[4][4+k] = flg_in[k];
            if (idu_en && idu_sel < 3'd6 && idu_op < 2'd2) begin
                res = (idu_op == 2'd0) ? m_r[idu_sel] + 16'd1 : m_r[idu_sel] - 16'd1;
                n_r[idu_sel] = res;
                n_idu = res;
            end
            if (wr16_en && wr16_sel < 3'd6) n_r[wr16_sel] = wr16_data;
            n_r[4][3:0] = 4'h0;
        end
    endtask

    task automatic idle();
        wr8_en = 1'b0; wr8_sel = 3'd0; wr8_data = 8'h00;
        wr16_en = 1'b0; wr16_sel = 3'd0; wr16_data = 16'h0000;
        idu_en = 1'b0; idu_sel = 3'd0; idu_op = 2'b10;
        flg_we = 4'h0; flg_in = 4'h0;
    endtask

    // One clock edge with model commit; strobes drop just after the edge
    task automatic tick();
        model_next();
        @(posedge clk);
        for (int i = 0; i < 6; i++) m_r[i] = n_r[i];
        m_idu = n_idu;
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        rd8a_sel = 3'd0; rd8b_sel = 3'd0; rd16_sel = 3'd4;
        model_reset();
        #12;
        n_checks++; if (pc_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL rst_pc_held: got %h want %h", pc_q, 16'h0000); end
        n_checks++; if (sp_q !== 16'hFFFE) begin n_errors++; $display("[TB] FAIL rst_sp_held: got %h want %h", sp_q, 16'hFFFE); end
        n_checks++; if (rd16_data !== 16'h01B0) begin n_errors++; $display("[TB] FAIL rst_af_held: got %h want %h", rd16_data, 16'h01B0); end
        wr16_en = 1'b1; wr16_sel = 3'd5; wr16_data = 16'h1111;
        tick();
        n_checks++; if (pc_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL rst_strobe_ignored: got %h want %h", pc_q, 16'h0000); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        rd16_sel = 3'd0;
        #1;
        n_checks++; if (rd16_data !== 16'h0000) begin n_errors++; $display("[TB] FAIL rst_bc: got %h want %h", rd16_data, 16'h0000); end
        n_checks++; if (hl_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL rst_hl: got %h want %h", hl_q, 16'h0000); end
        n_checks++; if (idu_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL rst_idu_q: got %h want %h", idu_q, 16'h0000); end
        n_checks++; if (sp_q !== 16'hFFFE) begin n_errors++; $display("[TB] FAIL rst_sp: got %h want %h", sp_q, 16'hFFFE); end
    endtask

    task automatic test_idu_wrap();
        wr16_en = 1'b1; wr16_sel = 3'd2; wr16_data = 16'hFFFF;
        tick();
        idu_en = 1'b1; idu_sel = 3'd2; idu_op = 2'b00;
        tick();
        n_checks++; if (hl_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL idu_inc_wrap_hl: got %h want %h", hl_q, 16'h0000); end
        n_checks++; if (idu_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL idu_inc_wrap_q: got %h want %h", idu_q, 16'h0000); end
        wr16_en = 1'b1; wr16_sel = 3'd3; wr16_data = 16'h0000;
        tick();
        idu_en = 1'b1; idu_sel = 3'd3; idu_op = 2'b01;
        tick();
        n_checks++; if (sp_q !== 16'hFFFF) begin n_errors++; $display("[TB] FAIL idu_dec_wrap_sp: got %h want %h", sp_q, 16'hFFFF); end
        n_checks++; if (idu_q !== 16'hFFFF) begin n_errors++; $display("[TB] FAIL idu_dec_wrap_q: got %h want %h", idu_q, 16'hFFFF); end
        idu_en = 1'b1; idu_sel = 3'd3; idu_op = 2'b10;
        tick();
        n_checks++; if (sp_q !== 16'hFFFF) begin n_errors++; $display("[TB] FAIL idu_hold_sp: got %h want %h", sp_q, 16'hFFFF); end
    endtask

    task automatic test_conflicts();
        wr16_en = 1'b1; wr16_sel = 3'd0; wr16_data = 16'h1234;
        wr8_en = 1'b1; wr8_sel = 3'd1; wr8_data = 8'h99;
        tick();
        rd16_sel = 3'd0;
        #1;
        n_checks++; if (rd16_data !== 16'h1234) begin n_errors++; $display("[TB] FAIL conflict_bc: got %h want %h", rd16_data, 16'h1234); end
        wr16_en = 1'b1; wr16_sel = 3'd1; wr16_data = 16'h5678;
        wr8_en = 1'b1; wr8_sel = 3'd7; wr8_data = 8'hAA;
        tick();
        rd16_sel = 3'd1; rd8a_sel = 3'd7;
        #1;
        n_checks++; if (rd16_data !== 16'h5678) begin n_errors++; $display("[TB] FAIL merge_de: got %h want %h", rd16_data, 16'h5678); end
        n_checks++; if (rd8a_data !== 8'hAA) begin n_errors++; $display("[TB] FAIL merge_a: got %h want %h", rd8a_data, 8'hAA); end
    endtask

    task automatic test_flags();
        wr8_en = 1'b1; wr8_sel = 3'd6; wr8_data = 8'hFF;
        flg_we = 4'b0001; flg_in = 4'b0000;
        tick();
        rd8a_sel = 3'd6;
        #1;
        n_checks++; if (rd8a_data !== 8'hE0) begin n_errors++; $display("[TB] FAIL flag_override: got %h want %h", rd8a_data, 8'hE0); end
        wr16_en = 1'b1; wr16_sel = 3'd4; wr16_data = 16'h12FF;
        tick();
        rd8b_sel = 3'd6; rd16_sel = 3'd4;
        #1;
        n_checks++; if (rd8b_data !== 8'hF0) begin n_errors++; $display("[TB] FAIL f_low_nibble: got %h want %h", rd8b_data, 8'hF0); end
        n_checks++; if (rd16_data !== 16'h12F0) begin n_errors++; $display("[TB] FAIL af_pair: got %h want %h", rd16_data, 16'h12F0); end
    endtask

    task automatic test_idu_vs_wr16();
        wr16_en = 1'b1; wr16_sel = 3'd0; wr16_data = 16'h1000;
        tick();
        wr16_en = 1'b1; wr16_sel = 3'd0; wr16_data = 16'hABCD;
        idu_en = 1'b1; idu_sel = 3'd0; idu_op = 2'b00;
        tick();
        rd16_sel = 3'd0;
        #1;
        n_checks++; if (rd16_data !== 16'hABCD) begin n_errors++; $display("[TB] FAIL idu_wr16_pair: got %h want %h", rd16_data, 16'hABCD); end
        n_checks++; if (idu_q !== 16'h1001) begin n_errors++; $display("[TB] FAIL idu_wr16_q: got %h want %h", idu_q, 16'h1001); end
        wr16_en = 1'b1; wr16_sel = 3'd6; wr16_data = 16'hDEAD;
        idu_en = 1'b1; idu_sel = 3'd7; idu_op = 2'b00;
        tick();
        rd16_sel = 3'd6;
        #1;
        n_checks++; if (rd16_data !== 16'h0000) begin n_errors++; $display("[TB] FAIL reserved_rd6: got %h want %h", rd16_data, 16'h0000); end
        n_checks++; if (idu_q !== 16'h1001) begin n_errors++; $display("[TB] FAIL reserved_idu: got %h want %h", idu_q, 16'h1001); end
    endtask

    task automatic test_bypass();
        logic [7:0] want;
        wr8_en = 1'b1; wr8_sel = 3'd0; wr8_data = 8'h11;
        tick();
        wr8_en = 1'b1; wr8_sel = 3'd0; wr8_data = 8'h5A;
        rd8a_sel = 3'd0;
        #1;
        want = BYPASS ? 8'h5A : 8'h11;
        n_checks++; if (rd8a_data !== want) begin n_errors++; $display("[TB] FAIL bypass_b: got %h want %h", rd8a_data, want); end
        tick();
        n_checks++; if (rd8a_data !== 8'h5A) begin n_errors++; $display("[TB] FAIL after_edge_b: got %h want %h", rd8a_data, 8'h5A); end
    endtask

    task automatic test_async_reset();
        wr16_en = 1'b1; wr16_sel = 3'd5; wr16_data = 16'hC000;
        rd16_sel = 3'd5;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (pc_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL async_pc: got %h want %h", pc_q, 16'h0000); end
        n_checks++; if (rd16_data !== 16'h0000) begin n_errors++; $display("[TB] FAIL async_rd16_pc: got %h want %h", rd16_data, 16'h0000); end
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++; if (pc_q !== 16'h0000) begin n_errors++; $display("[TB] FAIL async_release_pc: got %h want %h", pc_q, 16'h0000); end
        n_checks++; if (sp_q !== 16'hFFFE) begin n_errors++; $display("[TB] FAIL async_release_sp: got %h want %h", sp_q, 16'hFFFE); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            rd8a_sel  = 3'($urandom_range(0, 7));
            rd8b_sel  = 3'($urandom_range(0, 7));
            rd16_sel  = 3'($urandom_range(0, 7));
            wr8_en    = 1'($urandom_range(0, 1));
            wr8_sel   = 3'($urandom_range(0, 7));
            wr8_data  = 8'($urandom);
            wr16_en   = ($urandom_range(0, 2) == 0);
            wr16_sel  = 3'($urandom_range(0, 7));
            wr16_data = 16'($urandom);
            idu_en    = 1'($urandom_range(0, 1));
            idu_sel   = 3'($urandom_range(0, 7));
            idu_op    = 2'($urandom_range(0, 3));
            flg_we    = 4'($urandom);
            flg_in    = 4'($urandom);
            #1;
            model_next();
            n_checks++; if (rd8a_data !== exp8(rd8a_sel, BYPASS)) begin n_errors++; $display("[TB] FAIL rand_rd8a it=%0d: got %h want %h", it, rd8a_data, exp8(rd8a_sel, BYPASS)); end
            n_checks++; if (rd8b_data !== exp8(rd8b_sel, BYPASS)) begin n_errors++; $display("[TB] FAIL rand_rd8b it=%0d: got %h want %h", it, rd8b_data, exp8(rd8b_sel, BYPASS)); end
            n_checks++; if (rd16_data !== exp16(rd16_sel, BYPASS)) begin n_errors++; $display("[TB] FAIL rand_rd16 it=%0d: got %h want %h", it, rd16_data, exp16(rd16_sel, BYPASS)); end
            n_checks++; if (pc_q !== exp16(3'd5, BYPASS)) begin n_errors++; $display("[TB] FAIL rand_pc_pre it=%0d: got %h want %h", it, pc_q, exp16(3'd5, BYPASS)); end
            tick();
            n_checks++; if (idu_q !== m_idu) begin n_errors++; $display("[TB] FAIL rand_idu_q it=%0d: got %h want %h", it, idu_q, m_idu); end
            n_checks++; if (sp_q !== m_r[3]) begin n_errors++; $display("[TB] FAIL rand_sp it=%0d: got %h want %h", it, sp_q, m_r[3]); end
            n_checks++; if (hl_q !== m_r[2]) begin n_errors++; $display("[TB] FAIL rand_hl it=%0d: got %h want %h", it, hl_q, m_r[2]); end
            n_checks++; if (rd16_data !== exp16(rd16_sel, 1'b0)) begin n_errors++; $display("[TB] FAIL rand_rd16_post it=%0d: got %h want %h", it, rd16_data, exp16(rd16_sel, 1'b0)); end
        end
    endtask

    initial begin
        $display("[TB] sm83_regfile bench start (bypass=%0d)", BYPASS);
        test_reset();
        test_idu_wrap();
        test_conflicts();
        test_flags();
        test_idu_vs_wr16();
        test_bypass();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
